// File: rtl/petris_pkg.sv
// Operation codes and auto-repeat state shared by the input controller and the game logic.
// Priority helpers rank commands for the one-deep pending slot: start > drop > rotate > left > right.
package petris_pkg;

   localparam logic [2:0] OP_NONE   = 3'd0;
   localparam logic [2:0] OP_LEFT   = 3'd1;
   localparam logic [2:0] OP_RIGHT  = 3'd2;
   localparam logic [2:0] OP_ROTATE = 3'd3;
   localparam logic [2:0] OP_START  = 3'd4;
   localparam logic [2:0] OP_DROP   = 3'd5;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      REPEAT = 2'd2
   } rpt_state_t;

   function automatic logic [2:0] op_rank(input logic [2:0] op);
      case (op)
         OP_START:  return 3'd5;
         OP_DROP:   return 3'd4;
         OP_ROTATE: return 3'd3;
         OP_LEFT:   return 3'd2;
         OP_RIGHT:  return 3'd1;
         default:   return 3'd0;
      endcase
   endfunction

   // Ties keep the incumbent, so an equal-priority command never displaces the pending one.
   function automatic logic [2:0] op_max(input logic [2:0] incumbent, input logic [2:0] challenger);
      return (op_rank(challenger) > op_rank(incumbent)) ? challenger : incumbent;
   endfunction

endpackage

// File: rtl/button_debounce.sv
// Per-button 2-flop synchroniser, saturating debounce counter and one-cycle press pulse.
// Latency: raw edge to press is 2 + DEBOUNCE_CYCLES + 1 cycles; no backpressure.
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic level,
   output logic press
);

   localparam int            CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic          level_q;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1   <= 1'b0;
         sync2   <= 1'b0;
         level   <= 1'b0;
         level_q <= 1'b0;
         press   <= 1'b0;
         cnt     <= '0;
      end else begin
         sync1   <= btn;
         sync2   <= sync1;
         level_q <= level;
         press   <= level & ~level_q;
         // Count only while the synchronised level disagrees; any agreement restarts the window.
         if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            level <= sync2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/input_controller.sv
// Petris front end: debounced buttons -> one command per frame in operation, plus framenumber.
// Latency: command lands on the next frame boundary; no backpressure. Auto-repeat: INPUT_AUTOREPEAT_EN.
module input_controller
   import petris_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES     = 250000,
   parameter int REPEAT_DELAY_FRAMES = 12,
   parameter int REPEAT_RATE_FRAMES  = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       vsync,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_rotate,
   input  logic       btn_drop,
   input  logic       btn_start,
   output logic [2:0] operation,
   output logic [9:0] framenumber,
   output logic       frame_tick
);

   // Key index: 0 left, 1 right, 2 rotate, 3 drop, 4 start.
   logic [4:0] raw;
   logic [4:0] level;
   logic [4:0] press;
   logic [4:0] cmd;
   logic [2:0] raised;
   logic [2:0] pending;
   logic       vsync_q;

   assign raw = {btn_start, btn_drop, btn_rotate, btn_right, btn_left};

   for (genvar i = 0; i < 5; i++) begin : g_btn
      button_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk  (clk),
         .reset(reset),
         .btn  (raw[i]),
         .level(level[i]),
         .press(press[i])
      );
   end

`ifdef INPUT_AUTOREPEAT_EN
   localparam int FMAX = (REPEAT_DELAY_FRAMES > REPEAT_RATE_FRAMES) ? REPEAT_DELAY_FRAMES
                                                                    : REPEAT_RATE_FRAMES;
   localparam int             FCW        = (FMAX > 1) ? $clog2(FMAX) : 1;
   localparam logic [FCW-1:0] DELAY_LAST = FCW'(REPEAT_DELAY_FRAMES - 1);
   localparam logic [FCW-1:0] RATE_LAST  = FCW'(REPEAT_RATE_FRAMES - 1);

   logic [2:0] cmd_rpt;
   logic       unused_level;

   assign unused_level = level[2] ^ level[4];

   for (genvar j = 0; j < 3; j++) begin : g_rpt
      localparam int K = (j == 2) ? 3 : j;

      rpt_state_t     state, state_nx;
      logic [FCW-1:0] fcnt, fcnt_nx;
      logic           fire, fire_nx;

      always_ff @(posedge clk) begin
         if (reset) begin
            state <= IDLE;
            fcnt  <= '0;
            fire  <= 1'b0;
         end else begin
            state <= state_nx;
            fcnt  <= fcnt_nx;
            fire  <= fire_nx;
         end
      end

      // Repeat fires are registered, so they join the pending slot in the cycle after the boundary.
      always_comb begin
         state_nx = state;
         fcnt_nx  = fcnt;
         fire_nx  = 1'b0;
         if (!level[K]) begin
            state_nx = IDLE;
            fcnt_nx  = '0;
         end else begin
            case (state)
               IDLE: begin
                  if (press[K]) begin
                     state_nx = DELAY;
                     fcnt_nx  = '0;
                  end
               end
               DELAY: begin
                  if (frame_tick) begin
                     if (fcnt == DELAY_LAST) begin
                        state_nx = REPEAT;
                        fcnt_nx  = '0;
                        fire_nx  = 1'b1;
                     end else begin
                        fcnt_nx = fcnt + 1'b1;
                     end
                  end
               end
               REPEAT: begin
                  if (frame_tick) begin
                     if (fcnt == RATE_LAST) begin
                        fcnt_nx = '0;
                        fire_nx = 1'b1;
                     end else begin
                        fcnt_nx = fcnt + 1'b1;
                     end
                  end
               end
               default: begin
                  state_nx = IDLE;
                  fcnt_nx  = '0;
               end
            endcase
         end
      end

      always_comb begin
         cmd_rpt[j] = ((state == IDLE) && press[K]) || fire;
      end
   end

   assign cmd = {press[4], cmd_rpt[2], press[2], cmd_rpt[1], cmd_rpt[0]};
`else
   logic unused_level;

   assign unused_level = ^level;
   assign cmd          = press;
`endif

   always_comb begin
      raised = OP_NONE;
      if (cmd[4])      raised = OP_START;
      else if (cmd[3]) raised = OP_DROP;
      else if (cmd[2]) raised = OP_ROTATE;
      else if (cmd[0]) raised = OP_LEFT;
      else if (cmd[1]) raised = OP_RIGHT;
   end

   // A command raised in the boundary cycle itself is folded into that boundary's update.
   always_ff @(posedge clk) begin
      if (reset) begin
         vsync_q     <= 1'b0;
         frame_tick  <= 1'b0;
         pending     <= OP_NONE;
         operation   <= OP_NONE;
         framenumber <= '0;
      end else begin
         vsync_q    <= vsync;
         frame_tick <= vsync_q & ~vsync;
         if (frame_tick) begin
            operation   <= op_max(pending, raised);
            pending     <= OP_NONE;
            framenumber <= framenumber + 1'b1;
         end else begin
            pending <= op_max(pending, raised);
         end
      end
   end

endmodule
